// File: rtl/mips_alu_pkg.sv
// Shared encodings for the execute-stage ALU: ALU_OP classes, ALU control codes, R-type funct values.
package mips_alu_pkg;

    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned CTL_W   = 3;
    localparam int unsigned FUNCT_W = 6;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [ALUOP_W-1:0] ALUOP_OR    = 2'b11;

    localparam logic [CTL_W-1:0] CTL_AND = 3'b000;
    localparam logic [CTL_W-1:0] CTL_OR  = 3'b001;
    localparam logic [CTL_W-1:0] CTL_ADD = 3'b010;
    localparam logic [CTL_W-1:0] CTL_NOR = 3'b100;
    localparam logic [CTL_W-1:0] CTL_SUB = 3'b110;
    localparam logic [CTL_W-1:0] CTL_SLT = 3'b111;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/adder32.sv
// Ripple-agnostic adder with carry-in and carry-out; shared by the ALU and the PC incrementer.
module adder32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryIn,
    output logic [WIDTH-1:0] sum,
    output logic             carryOut
);

    assign {carryOut, sum} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carryIn);

endmodule

// File: rtl/mips_alu_unit.sv
// Execute-stage block: ALU-control decode, 32-bit ALU with registered result/flags, and PC+4.
module mips_alu_unit
    import mips_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               En,
    input  logic [WIDTH-1:0]   In1,
    input  logic [WIDTH-1:0]   In2,
    input  logic [FUNCT_W-1:0] Funct,
    input  logic [ALUOP_W-1:0] ALU_OP,
    input  logic [WIDTH-1:0]   PC,
    output logic [CTL_W-1:0]   Control,
    output logic [WIDTH-1:0]   PCPlus4,
    output logic [WIDTH-1:0]   Out,
    output logic               Zero,
    output logic               Overflow,
    output logic               Valid
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    logic             isSub;
    logic [WIDTH-1:0] addB;
    logic [WIDTH-1:0] addSum;
    logic             addOvf;
    logic             sltBit;
    logic [WIDTH-1:0] result;
    logic             resultOvf;
    logic             unusedAluCout;
    logic             unusedPcCout;

    // ALU-control decode
    always_comb begin
        Control = CTL_ADD;
        case (ALU_OP)
            ALUOP_ADD: Control = CTL_ADD;
            ALUOP_SUB: Control = CTL_SUB;
            ALUOP_OR:  Control = CTL_OR;
            default: begin
                case (Funct)
                    FUNCT_ADD: Control = CTL_ADD;
                    FUNCT_SUB: Control = CTL_SUB;
                    FUNCT_AND: Control = CTL_AND;
                    FUNCT_OR:  Control = CTL_OR;
                    FUNCT_NOR: Control = CTL_NOR;
                    FUNCT_SLT: Control = CTL_SLT;
                    default:   Control = CTL_ADD;
                endcase
            end
        endcase
    end

    // SUB and SLT both run In1 + ~In2 + 1 through the shared adder
    assign isSub = (Control == CTL_SUB) || (Control == CTL_SLT);
    assign addB  = isSub ? ~In2 : In2;

    adder32 #(.WIDTH(WIDTH)) uAluAdd (
        .a        (In1),
        .b        (addB),
        .carryIn  (isSub),
        .sum      (addSum),
        .carryOut (unusedAluCout)
    );

    assign addOvf = (In1[WIDTH-1] == addB[WIDTH-1]) && (addSum[WIDTH-1] != In1[WIDTH-1]);
    // Sign of the difference corrected by overflow gives the true signed less-than
    assign sltBit = addSum[WIDTH-1] ^ addOvf;

    adder32 #(.WIDTH(WIDTH)) uPcAdd (
        .a        (PC),
        .b        (PC_STEP),
        .carryIn  (1'b0),
        .sum      (PCPlus4),
        .carryOut (unusedPcCout)
    );

    // ALU result mux
    always_comb begin
        result    = '0;
        resultOvf = 1'b0;
        case (Control)
            CTL_AND: result = In1 & In2;
            CTL_OR:  result = In1 | In2;
            CTL_NOR: result = ~(In1 | In2);
            CTL_ADD, CTL_SUB: begin
                result    = addSum;
                resultOvf = addOvf;
            end
            CTL_SLT: result = WIDTH'(sltBit);
            default: result = '0;
        endcase
    end

    // Output registers; result and flags hold while En is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Out      <= '0;
            Zero     <= 1'b0;
            Overflow <= 1'b0;
            Valid    <= 1'b0;
        end else begin
            Valid <= En;
            if (En) begin
                Out      <= result;
                Zero     <= (result == '0);
                Overflow <= resultOvf;
            end
        end
    end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Self-checking bench for mips_alu_unit: directed tables, corner sequences and a randomized model check.
module tb_mips_alu_unit;

    logic        clk;
    logic        rst;
    logic        En;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [5:0]  Funct;
    logic [1:0]  ALU_OP;
    logic [31:0] PC;
    logic [2:0]  Control;
    logic [31:0] PCPlus4;
    logic [31:0] Out;
    logic        Zero;
    logic        Overflow;
    logic        Valid;

    int passCnt  = 0;
    int totalCnt = 0;

    mips_alu_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .En       (En),
        .In1      (In1),
        .In2      (In2),
        .Funct    (Funct),
        .ALU_OP   (ALU_OP),
        .PC       (PC),
        .Control  (Control),
        .PCPlus4  (PCPlus4),
        .Out      (Out),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Valid    (Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [2:0] ctl;
    } decVec_t;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        zero;
        logic        ovf;
    } aluVec_t;

    decVec_t decVecs[10];
    aluVec_t aluVecs[13];

    // model state of the output registers
    logic [31:0] mOut;
    logic        mZero;
    logic        mOvf;
    logic        mValid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Operation name from the instruction-level rules
    function automatic string refOp(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return "add";
        if (op == 2'b01) return "sub";
        if (op == 2'b11) return "or";
        case (f)
            6'b100010: return "sub";
            6'b100100: return "and";
            6'b100101: return "or";
            6'b100111: return "nor";
            6'b101010: return "slt";
            default:   return "add";
        endcase
    endfunction

    function automatic logic [2:0] refCtl(input string name);
        case (name)
            "and": return 3'b000;
            "or":  return 3'b001;
            "nor": return 3'b100;
            "sub": return 3'b110;
            "slt": return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Arithmetic done on wide signed integers; overflow = result outside 32-bit signed range
    task automatic refAlu(input string name, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf);
        longint sa;
        longint sb;
        longint s;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = 1'b0;
        res = 32'h0;
        case (name)
            "and": res = a & b;
            "or":  res = a | b;
            "nor": res = ~(a | b);
            "slt": res = (sa < sb) ? 32'd1 : 32'd0;
            default: begin
                s   = (name == "sub") ? sa - sb : sa + sb;
                res = s[31:0];
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
        endcase
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] corners[6];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFFFFFF;
        corners[3] = 32'h7FFFFFFF;
        corners[4] = 32'h80000000;
        corners[5] = 32'h80000001;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic driveOp(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic en);
        ALU_OP = op;
        Funct  = f;
        In1    = a;
        In2    = b;
        En     = en;
    endtask

    initial begin
        logic [31:0] eOut;
        logic        eOvf;
        logic [5:0]  functs[7];
        string       opName;

        decVecs[0] = '{2'b00, 6'b101010, 3'b010};
        decVecs[1] = '{2'b01, 6'b100100, 3'b110};
        decVecs[2] = '{2'b11, 6'b100111, 3'b001};
        decVecs[3] = '{2'b10, 6'b100000, 3'b010};
        decVecs[4] = '{2'b10, 6'b100010, 3'b110};
        decVecs[5] = '{2'b10, 6'b100100, 3'b000};
        decVecs[6] = '{2'b10, 6'b100101, 3'b001};
        decVecs[7] = '{2'b10, 6'b100111, 3'b100};
        decVecs[8] = '{2'b10, 6'b101010, 3'b111};
        decVecs[9] = '{2'b10, 6'b111111, 3'b010};

        aluVecs[0]  = '{2'b01, 6'b000000, 32'd7,        32'd7,        32'h00000000, 1'b1, 1'b0};
        aluVecs[1]  = '{2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1};
        aluVecs[2]  = '{2'b10, 6'b100010, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1};
        aluVecs[3]  = '{2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0, 1'b0};
        aluVecs[4]  = '{2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0};
        aluVecs[5]  = '{2'b10, 6'b101010, 32'd5,        32'hFFFFFFFE, 32'h00000000, 1'b1, 1'b0};
        aluVecs[6]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
        aluVecs[7]  = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
        aluVecs[8]  = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0, 1'b0};
        aluVecs[9]  = '{2'b11, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
        aluVecs[10] = '{2'b10, 6'b111111, 32'd2,        32'd3,        32'h00000005, 1'b0, 1'b0};
        aluVecs[11] = '{2'b00, 6'b000000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
        aluVecs[12] = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0};

        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b100111; functs[5] = 6'b101010;
        functs[6] = 6'b000000;

        // Reset held with a pending ADD on the inputs
        rst = 1'b0;
        PC  = 32'h0;
        driveOp(2'b00, 6'b000000, 32'd5, 32'd3, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.Out", Out, 32'h0);
        check("rst.Zero", 32'(Zero), 32'h0);
        check("rst.Overflow", 32'(Overflow), 32'h0);
        check("rst.Valid", 32'(Valid), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first.Out", Out, 32'd8);
        check("first.Valid", 32'(Valid), 32'h1);
        check("first.Zero", 32'(Zero), 32'h0);

        // Decode sweep
        foreach (decVecs[i]) begin
            ALU_OP = decVecs[i].op;
            Funct  = decVecs[i].funct;
            #1;
            check($sformatf("dec%0d.Control", i), 32'(Control), 32'(decVecs[i].ctl));
        end

        // Directed ALU vectors, one per cycle
        foreach (aluVecs[i]) begin
            @(negedge clk);
            driveOp(aluVecs[i].op, aluVecs[i].funct, aluVecs[i].a, aluVecs[i].b, 1'b1);
            @(posedge clk); #1;
            check($sformatf("alu%0d.Out", i), Out, aluVecs[i].out);
            check($sformatf("alu%0d.Zero", i), 32'(Zero), 32'(aluVecs[i].zero));
            check($sformatf("alu%0d.Overflow", i), 32'(Overflow), 32'(aluVecs[i].ovf));
            check($sformatf("alu%0d.Valid", i), 32'(Valid), 32'h1);
        end

        // Hold: produce 8, then drop En with new inputs
        @(negedge clk);
        driveOp(2'b00, 6'b000000, 32'd5, 32'd3, 1'b1);
        @(posedge clk); #1;
        check("hold.setup", Out, 32'd8);
        @(negedge clk);
        driveOp(2'b01, 6'b000000, 32'd100, 32'd100, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("hold.Out", Out, 32'd8);
            check("hold.Valid", 32'(Valid), 32'h0);
            check("hold.Zero", 32'(Zero), 32'h0);
        end

        // Incrementer
        PC = 32'h00400000; #1;
        check("pc.normal", PCPlus4, 32'h00400004);
        PC = 32'hFFFFFFFC; #1;
        check("pc.wrap", PCPlus4, 32'h0);

        // Asynchronous reset mid-operation drops the in-flight result
        @(negedge clk);
        driveOp(2'b00, 6'b000000, 32'd1, 32'd1, 1'b1);
        @(posedge clk); #1;
        check("midrst.pre", Out, 32'd2);
        #2 rst = 1'b0;
        #1;
        check("midrst.Out", Out, 32'h0);
        check("midrst.Valid", 32'(Valid), 32'h0);
        @(posedge clk); #1;
        check("midrst.held", Out, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        En  = 1'b0;
        @(posedge clk); #1;
        check("midrst.noEn.Out", Out, 32'h0);
        check("midrst.noEn.Valid", 32'(Valid), 32'h0);

        // Randomized run against the reference model
        mOut = 32'h0; mZero = 1'b0; mOvf = 1'b0; mValid = 1'b0;
        for (int n = 0; n < 300; n++) begin
            logic [1:0]  op;
            logic [5:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            logic        en;
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 1) == 0) ? functs[$urandom_range(0, 6)] : 6'($urandom_range(0, 63));
            a  = pickOperand();
            b  = pickOperand();
            en = (n == 0) ? 1'b1 : ($urandom_range(0, 4) != 0);
            driveOp(op, f, a, b, en);
            PC = $urandom;
            #1;
            opName = refOp(op, f);
            check($sformatf("rnd%0d.Control", n), 32'(Control), 32'(refCtl(opName)));
            check($sformatf("rnd%0d.PCPlus4", n), PCPlus4, PC + 32'd4);
            refAlu(opName, a, b, eOut, eOvf);
            if (en) begin
                mOut  = eOut;
                mZero = (eOut == 32'h0);
                mOvf  = eOvf;
            end
            mValid = en;
            @(posedge clk); #1;
            check($sformatf("rnd%0d.Out", n), Out, mOut);
            check($sformatf("rnd%0d.Zero", n), 32'(Zero), 32'(mZero));
            check($sformatf("rnd%0d.Overflow", n), 32'(Overflow), 32'(mOvf));
            check($sformatf("rnd%0d.Valid", n), 32'(Valid), 32'(mValid));
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/mips_alu_unit.md
# mips_alu_unit

Execute-stage arithmetic block for the single-cycle MIPS datapath. It merges three pieces of logic:
- the ALU-control decoder, which turns `ALU_OP` plus `funct` into a 3-bit operation code;
- the 32-bit ALU;
- the PC+4 incrementer.

The ALU result, zero flag and overflow flag are registered, giving one cycle of latency. `Control` and `PCPlus4` are combinational so the datapath can see them in the same cycle.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is required to be supported.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `En` input 1: when 1, the ALU output registers capture on the clock edge.
- `In1` input 32: ALU operand A (rs).
- `In2` input 32: ALU operand B (rt or sign-extended immediate).
- `Funct` input 6: instruction bits [5:0].
- `ALU_OP` input 2: operation class from ControlUnit.
- `PC` input 32: current program counter.
- `Control` output 3: decoded ALU operation, combinational.
- `PCPlus4` output 32: `PC + 4` modulo 2^32, combinational.
- `Out` output 32: registered ALU result.
- `Zero` output 1: registered; 1 when the captured result is 0.
- `Overflow` output 1: registered signed overflow for ADD/SUB.
- `Valid` output 1: registered copy of `En`.

## Operation
ALU-control decode, by `ALU_OP`:
- 00 → ADD (3'b010). Used by lw/sw.
- 01 → SUB (3'b110). Used by beq.
- 10 → decode `Funct`:
  - 100000 → ADD 010
  - 100010 → SUB 110
  - 100100 → AND 000
  - 100101 → OR 001
  - 100111 → NOR 100
  - 101010 → SLT 111
  - any other `Funct` → ADD 010
- 11 → OR (001). Used by ori.

ALU, selected by `Control`:
- AND: `In1 & In2`.
- OR: `In1 | In2`.
- NOR: `~(In1 | In2)`.
- ADD: `In1 + In2`, wrap modulo 2^32.
- SUB: `In1 - In2`, computed as `In1 + ~In2 + 1`.
- SLT: 32'd1 if `$signed(In1) < $signed(In2)`, else 0. The comparison must be correct even when the subtraction overflows.
- Unused codes 011 and 101: result 0.

Flags:
- `Overflow` is set only for ADD/SUB: operand signs agree (after the `In2` inversion for SUB) and the result sign differs. It is 0 for every other operation.
- `Zero` is `(result == 0)` for every operation.

Incrementer: `PCPlus4` wraps, so 32'hFFFFFFFC + 4 = 0.

## Timing
- Reset (`rst` = 0, asynchronous): `Out` = 0, `Zero` = 0, `Overflow` = 0, `Valid` = 0, immediately and held while low. `Zero` resets to 0 even though `Out` is 0; it is meaningful only when `Valid` = 1.
- Reset release: registers are first updated on the first rising edge after `rst` goes high.
- `En` = 1 at edge N: `Out`, `Zero` and `Overflow` reflect the inputs sampled at edge N and are valid after edge N. `Valid` = 1 in the same cycle. Latency is 1 cycle; a new operation can start every cycle.
- `En` = 0: `Out`, `Zero` and `Overflow` hold their values and `Valid` goes to 0 at the next edge.
- `Control` and `PCPlus4` have no latency and are unaffected by `En` or reset.
- Reset asserted mid-operation: any in-flight result is discarded.

## Structure
- Package `mips_alu_pkg` holds:
  - `ALU_OP` codes (`ALUOP_ADD` = 00, `ALUOP_SUB` = 01, `ALUOP_FUNCT` = 10, `ALUOP_OR` = 11);
  - 3-bit control codes (`CTL_AND`, `CTL_OR`, `CTL_ADD`, `CTL_NOR`, `CTL_SUB`, `CTL_SLT`);
  - the six `Funct` constants.
- One sub-module, `adder32`, is a 32-bit adder with carry-in, sum and carry-out.
  - One instance serves ADD/SUB/SLT.
  - A second instance computes `PC` + 4.
- The decoder and ALU mux stay in the top module as combinational processes, followed by the output register process.

## Test plan
- Reset:
  - Hold `rst` = 0 with `En` = 1 and `In1` = 5, `In2` = 3 → `Out` = 0, `Zero` = 0, `Overflow` = 0, `Valid` = 0.
  - Release reset, then one edge → `Out` = 8, `Valid` = 1.
- Decode sweep: check `Control` for each case.
  - `ALU_OP` 00 → 010; 01 → 110; 11 → 001.
  - `ALU_OP` 10 with `Funct` 100100 → 000; 100111 → 100; 101010 → 111; 111111 → 010.
- Arithmetic:
  - SUB 7 − 7 → `Out` = 0, `Zero` = 1.
  - ADD 32'h7FFFFFFF + 1 → `Out` = 32'h80000000, `Overflow` = 1.
  - SUB 32'h80000000 − 1 → `Out` = 32'h7FFFFFFF, `Overflow` = 1.
- SLT:
  - `In1` = 32'hFFFFFFFF (−1), `In2` = 1 → `Out` = 1.
  - `In1` = 32'h80000000, `In2` = 32'h7FFFFFFF → `Out` = 1 (overflow case).
  - `In1` = 5, `In2` = −2 → `Out` = 0.
- Logic:
  - `In1` = 32'hF0F0F0F0, `In2` = 32'h0FF00FF0.
  - AND → 32'h00F000F0; OR → 32'hFFF0FFF0; NOR → 32'h000F000F.
- Hold and incrementer:
  - Drop `En` after a result of 8 and change the inputs → `Out` stays 8, `Valid` = 0.
  - `PC` = 32'h00400000 → `PCPlus4` = 32'h00400004.
  - `PC` = 32'hFFFFFFFC → `PCPlus4` = 0.
